// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite bus between the core's data-port master and the SRAM-backed slave.
interface axi_lite_sram_if;
  logic        mem_awvalid;
  logic        mem_awready;
  logic [31:0] mem_awaddr;
  logic        mem_wvalid;
  logic        mem_wready;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_bvalid;
  logic        mem_bready;
  logic [1:0]  mem_bresp;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;

  modport master (
    output mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    output mem_arvalid, mem_araddr, mem_rready,
    input  mem_awready, mem_wready, mem_bvalid, mem_bresp,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp
  );

  modport slave (
    input  mem_awvalid, mem_awaddr, mem_wvalid, mem_wdata, mem_wstrb, mem_bready,
    input  mem_arvalid, mem_araddr, mem_rready,
    output mem_awready, mem_wready, mem_bvalid, mem_bresp,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp
  );
endinterface

// File: rtl/axi_lite_sram_slave.sv
// AXI4-Lite slave serving a word-addressed internal SRAM through independent read
// and write FSMs, each with a programmable response latency.
module axi_lite_sram_slave #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          DEPTH  = 4096,
  parameter int          RD_LAT = 2,
  parameter int          WR_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  axi_lite_sram_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int RCW   = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int WCW   = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;
  localparam logic [RCW-1:0] RD_CNT_INIT = RCW'(RD_LAT - 1);
  localparam logic [WCW-1:0] WR_CNT_INIT = WCW'(WR_LAT - 1);
  localparam logic [RCW-1:0] RD_CNT_ZERO = {RCW{1'b0}};
  localparam logic [WCW-1:0] WR_CNT_ZERO = {WCW{1'b0}};
  localparam logic [32:0]    LIMIT       = {1'b0, BASE} + 33'(4 * DEPTH);
  localparam logic [1:0]     RESP_OKAY   = 2'b00;
  localparam logic [1:0]     RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [2:0] {
    W_IDLE = 3'd0,
    W_GOTA = 3'd1,
    W_GOTD = 3'd2,
    W_WAIT = 3'd3,
    W_RESP = 3'd4
  } wr_state_e;

  // 33-bit compare so the upper bound cannot wrap when BASE sits near the top of the map
  function automatic logic addr_in_range(input logic [31:0] addr);
    return ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < LIMIT);
  endfunction

  logic [31:0] mem [DEPTH];

  rd_state_e      rd_state_r;
  rd_state_e      rd_state_nxt_s;
  logic [RCW-1:0] rd_cnt_r;
  logic [31:0]    rd_addr_r;
  logic [31:0]    rdata_r;
  logic [1:0]     rresp_r;
  logic           arready_s;
  logic           rvalid_s;
  logic           ar_hs_s;
  logic [31:0]    rd_off_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic           rd_in_range_s;

  wr_state_e      wr_state_r;
  wr_state_e      wr_state_nxt_s;
  logic [WCW-1:0] wr_cnt_r;
  logic [31:0]    wr_addr_r;
  logic [31:0]    wr_data_r;
  logic [3:0]     wr_strb_r;
  logic [1:0]     bresp_r;
  logic           awready_s;
  logic           wready_s;
  logic           bvalid_s;
  logic           aw_hs_s;
  logic           w_hs_s;
  logic [31:0]    wr_off_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic           wr_in_range_s;
  logic           wr_commit_s;

  logic           unused_bits_s;

  assign ar_hs_s       = bus.mem_arvalid & arready_s;
  assign rd_off_s      = rd_addr_r - BASE;
  assign rd_idx_s      = rd_off_s[IDX_W+1:2];
  assign rd_in_range_s = addr_in_range(rd_addr_r);

  assign aw_hs_s       = bus.mem_awvalid & awready_s;
  assign w_hs_s        = bus.mem_wvalid & wready_s;
  assign wr_off_s      = wr_addr_r - BASE;
  assign wr_idx_s      = wr_off_s[IDX_W+1:2];
  assign wr_in_range_s = addr_in_range(wr_addr_r);
  // A zero byte-strobe is a legal no-op write: OKAY response but nothing committed
  assign wr_commit_s   = (wr_state_r == W_WAIT) && (wr_cnt_r == WR_CNT_ZERO) &&
                         wr_in_range_s && (wr_strb_r != 4'b0000) && !rst;

  assign unused_bits_s = ^{bus.mem_wstrb[7:4], rd_off_s[31:IDX_W+2], rd_off_s[1:0],
                           wr_off_s[31:IDX_W+2], wr_off_s[1:0]};

  // Read FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_r <= R_IDLE;
    end else begin
      rd_state_r <= rd_state_nxt_s;
    end
  end

  // Read FSM next-state logic
  always_comb begin
    rd_state_nxt_s = rd_state_r;
    case (rd_state_r)
      R_IDLE: begin
        if (ar_hs_s) rd_state_nxt_s = R_WAIT;
        else         rd_state_nxt_s = R_IDLE;
      end
      R_WAIT: begin
        if (rd_cnt_r == RD_CNT_ZERO) rd_state_nxt_s = R_RESP;
        else                         rd_state_nxt_s = R_WAIT;
      end
      R_RESP: begin
        if (bus.mem_rready) rd_state_nxt_s = R_IDLE;
        else                rd_state_nxt_s = R_RESP;
      end
      default: rd_state_nxt_s = R_IDLE;
    endcase
  end

  // Read FSM outputs decoded from the state register
  always_comb begin
    arready_s = 1'b0;
    rvalid_s  = 1'b0;
    case (rd_state_r)
      R_IDLE:  arready_s = 1'b1;
      R_RESP:  rvalid_s  = 1'b1;
      default: begin
        arready_s = 1'b0;
        rvalid_s  = 1'b0;
      end
    endcase
  end

  // Read datapath: address latch, latency counter and response capture
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_r  <= RD_CNT_ZERO;
      rd_addr_r <= 32'h0;
      rdata_r   <= 32'h0;
      rresp_r   <= RESP_OKAY;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          rd_cnt_r <= RD_CNT_INIT;
          if (ar_hs_s) rd_addr_r <= bus.mem_araddr;
        end
        R_WAIT: begin
          // Sampling here sees the pre-edge array, so a same-edge write commit returns old data
          if (rd_cnt_r == RD_CNT_ZERO) begin
            rdata_r <= rd_in_range_s ? mem[rd_idx_s] : 32'h0;
            rresp_r <= rd_in_range_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            rd_cnt_r <= rd_cnt_r - RCW'(1);
          end
        end
        default: rd_cnt_r <= rd_cnt_r;
      endcase
    end
  end

  // Write FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_r <= W_IDLE;
    end else begin
      wr_state_r <= wr_state_nxt_s;
    end
  end

  // Write FSM next-state logic
  always_comb begin
    wr_state_nxt_s = wr_state_r;
    case (wr_state_r)
      W_IDLE: begin
        if (aw_hs_s && w_hs_s) wr_state_nxt_s = W_WAIT;
        else if (aw_hs_s)      wr_state_nxt_s = W_GOTA;
        else if (w_hs_s)       wr_state_nxt_s = W_GOTD;
        else                   wr_state_nxt_s = W_IDLE;
      end
      W_GOTA: begin
        if (w_hs_s) wr_state_nxt_s = W_WAIT;
        else        wr_state_nxt_s = W_GOTA;
      end
      W_GOTD: begin
        if (aw_hs_s) wr_state_nxt_s = W_WAIT;
        else         wr_state_nxt_s = W_GOTD;
      end
      W_WAIT: begin
        if (wr_cnt_r == WR_CNT_ZERO) wr_state_nxt_s = W_RESP;
        else                         wr_state_nxt_s = W_WAIT;
      end
      W_RESP: begin
        if (bus.mem_bready) wr_state_nxt_s = W_IDLE;
        else                wr_state_nxt_s = W_RESP;
      end
      default: wr_state_nxt_s = W_IDLE;
    endcase
  end

  // Write FSM outputs decoded from the state register
  always_comb begin
    awready_s = 1'b0;
    wready_s  = 1'b0;
    bvalid_s  = 1'b0;
    case (wr_state_r)
      W_IDLE: begin
        awready_s = 1'b1;
        wready_s  = 1'b1;
      end
      W_GOTA:  wready_s  = 1'b1;
      W_GOTD:  awready_s = 1'b1;
      W_RESP:  bvalid_s  = 1'b1;
      default: begin
        awready_s = 1'b0;
        wready_s  = 1'b0;
        bvalid_s  = 1'b0;
      end
    endcase
  end

  // Write datapath: address/data latches, latency counter and response code
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_r  <= WR_CNT_ZERO;
      wr_addr_r <= 32'h0;
      wr_data_r <= 32'h0;
      wr_strb_r <= 4'b0000;
      bresp_r   <= RESP_OKAY;
    end else begin
      if (aw_hs_s) wr_addr_r <= bus.mem_awaddr;
      if (w_hs_s) begin
        wr_data_r <= bus.mem_wdata;
        wr_strb_r <= bus.mem_wstrb[3:0];
      end
      case (wr_state_r)
        W_IDLE, W_GOTA, W_GOTD: wr_cnt_r <= WR_CNT_INIT;
        W_WAIT: begin
          if (wr_cnt_r == WR_CNT_ZERO) begin
            bresp_r <= wr_in_range_s ? RESP_OKAY : RESP_SLVERR;
          end else begin
            wr_cnt_r <= wr_cnt_r - WCW'(1);
          end
        end
        default: wr_cnt_r <= wr_cnt_r;
      endcase
    end
  end

  // SRAM byte-lane commit; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (wr_commit_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb_r[b]) mem[wr_idx_s][8*b +: 8] <= wr_data_r[8*b +: 8];
      end
    end
  end

  assign bus.mem_arready = arready_s;
  assign bus.mem_rvalid  = rvalid_s;
  assign bus.mem_rdata   = rdata_r;
  assign bus.mem_rresp   = rresp_r;
  assign bus.mem_awready = awready_s;
  assign bus.mem_wready  = wready_s;
  assign bus.mem_bvalid  = bvalid_s;
  assign bus.mem_bresp   = bresp_r;
endmodule
